// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift sequencer: op encodings, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH = 6;
    localparam int ALU_CNTW  = 6;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shift of a WIDTH vector selected by op (SRA/SRL/SLL, ROR when enabled).
// Latency: combinational.
// Backpressure: none.
// Ports: d (vector in), op (shift opcode), q (vector shifted by one position).
// ALU_SHIFT_ROTATE_EN: when defined op=11 rotates right by one; otherwise op=11 passes d through.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
            OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
`ifdef ALU_SHIFT_ROTATE_EN
            OP_ROR:  q = {d[0], d[WIDTH-1:1]};
`endif
            default: q = d;
        endcase
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter: accepts (a, b, op), shifts one bit per clock, presents result s.
// Latency: n+1 cycles from accept edge to out_valid, n = min(b, WIDTH) (ROR: n = b).
// Backpressure: result held in DONE while out_ready=0 (in_ready=0); accepts back-to-back in DONE when out_ready=1.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b/op request side;
//        out_valid/out_ready/s result side; busy high in SHIFT or DONE.
// ALU_SHIFT_ROTATE_EN: when defined op=11 rotates right by b; otherwise op=11 returns a after 1 cycle.
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNTW  = ALU_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [CNTW-1:0]  b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             busy
);

    localparam logic [CNTW-1:0] WIDTH_CNT = CNTW'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] step_q;
    logic [1:0]       opr;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_load;
    logic             accept;
    logic             shift_en;

    // Shifting further than WIDTH changes nothing for the linear shifts, so
    // the count saturates there; rotate keeps the full amount.
    always_comb begin
        cnt_load = '0;
        if (op == OP_ROR) begin
`ifdef ALU_SHIFT_ROTATE_EN
            cnt_load = b;
`else
            cnt_load = '0;
`endif
        end else begin
            cnt_load = (b > WIDTH_CNT) ? WIDTH_CNT : b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The edge that sees count=0 only moves to DONE; no extra shift.
                if (cnt != '0) begin
                    shift_en = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .d  (sreg),
        .op (opr),
        .q  (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            opr       <= OP_SRA;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                sreg <= a;
                opr  <= op;
                cnt  <= cnt_load;
            end else if (shift_en) begin
                sreg <= step_q;
                cnt  <= cnt - CNTW'(1);
            end
            // Status flags track the state being entered so they are registered
            // yet aligned with the state they describe.
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // sreg only moves on accept or while shifting, so s is stable in DONE.
    assign s = sreg;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
module tb_alu_shift_sequencer;
    import alu_pkg::*;

    localparam int W  = 6;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [CW-1:0] b = '0;
    logic [1:0]    op = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  s;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    alu_shift_sequencer #(.WIDTH(W), .CNTW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: result of shifting x by n as defined by the op semantics.
    function automatic int ref_s(input int x, input int n, input int o);
        logic [W-1:0]        v;
        logic signed [W-1:0] sv;
        logic [2*W-1:0]      dbl;
        v = W'(x);
        case (o)
            0: begin
                if (n >= W) begin
                    return v[W-1] ? (1 << W) - 1 : 0;
                end
                sv = v;
                sv = sv >>> n;
                return int'(unsigned'(sv));
            end
            1: return (n >= W) ? 0 : int'(v) >> n;
            2: return (n >= W) ? 0 : (int'(v) << n) & ((1 << W) - 1);
            default: begin
`ifdef ALU_SHIFT_ROTATE_EN
                dbl = {v, v} >> (n % W);
                return int'(dbl[W-1:0]);
`else
                dbl = '0;
                return int'(v);
`endif
            end
        endcase
    endfunction

    function automatic int ref_lat(input int n, input int o);
        if (o == 3) begin
`ifdef ALU_SHIFT_ROTATE_EN
            return n + 1;
`else
            return 1;
`endif
        end
        return ((n < W) ? n : W) + 1;
    endfunction

    // Called at posedge+1 with in_ready expected high; returns at posedge+1 after the accept edge.
    task automatic accept_req(input int av, input int bv, input int ov);
        chk("in_ready_before_accept", int'(in_ready), 1);
        in_valid = 1'b1;
        a  = W'(av);
        b  = CW'(bv);
        op = 2'(ov);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs; they must be ignored while busy.
        a  = W'($urandom);
        b  = CW'($urandom);
        op = 2'($urandom);
        chk("busy_after_accept", int'(busy), 1);
        chk("out_valid_after_accept", int'(out_valid), 0);
    endtask

    task automatic wait_result(input string tag, input int exp_s, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 100);
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_s"}, int'(s), exp_s);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_in_ready", int'(in_ready), 1);
        chk("drain_busy", int'(busy), 0);
    endtask

    initial begin
        bit pending;
        int ra, rb, ro;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s", int'(s), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SRA by 3
        accept_req(32, 3, 0);
        wait_result("sra3", 60, 4);
        drain();

        // SRL then back-to-back SLL accepted on the DONE cycle
        accept_req(32, 3, 1);
        wait_result("srl3", 4, 4);
        accept_req(5, 2, 2);
        wait_result("sll2_b2b", 20, 3);
        drain();

        // Saturating amounts
        accept_req(32, 9, 0);
        wait_result("sra9", 63, 7);
        drain();
        accept_req(32, 9, 1);
        wait_result("srl9", 0, 7);
        drain();

        // Zero shift and backpressure hold
        out_ready = 1'b0;
        accept_req(17, 0, 2);
        wait_result("sll0", 17, 1);
        in_valid = 1'b1;
        a = W'(3);
        b = CW'(1);
        op = 2'b01;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_s", int'(s), 17);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during SHIFT
        accept_req(32, 5, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_s", int'(s), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept_req(8, 1, 1);
        wait_result("after_rst", 4, 2);
        drain();

        // op=11
`ifdef ALU_SHIFT_ROTATE_EN
        accept_req(1, 1, 3);
        wait_result("ror1", 32, 2);
        drain();
        accept_req(1, 7, 3);
        wait_result("ror7", 32, 8);
        drain();
`else
        accept_req(1, 7, 3);
        wait_result("op11_pass", 1, 1);
        drain();
`endif

        // Randomized requests against the reference model, mixing drained and back-to-back
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << CW) - 1));
            if ($urandom_range(0, 2) == 0) rb = rb % 8;
            ro = int'($urandom_range(0, 3));
            accept_req(ra, rb, ro);
            wait_result("rand", ref_s(ra, rb, ro), ref_lat(rb, ro));
            pending = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                drain();
                pending = 1'b0;
            end
        end
        if (pending) drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
